// File: rtl/regfile_mp_ppp.sv
// Register file with two partition-masked write ports, NUM_RD combinational read ports and a sweep-clear engine.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp_ppp #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 3,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wrEn0,
    input  logic                         wrEn1,
    input  logic [ADDR_WIDTH-1:0]        wrAddr0,
    input  logic [ADDR_WIDTH-1:0]        wrAddr1,
    input  logic [0:DATA_WIDTH-1]        dataIn0,
    input  logic [0:DATA_WIDTH-1]        dataIn1,
    input  logic [2:0]                   ppp0,
    input  logic [2:0]                   ppp1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rdAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] dataOut,
    input  logic                         clrReq,
    output logic                         clrBusy,
    output logic                         clrDone,
    output logic                         wrRdy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [ADDR_WIDTH-1:0] pointer_next;
    logic                  done_flag;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NB-1:0]         mask0;
    logic [NB-1:0]         mask1;

    // Byte b of the entry is byte b counted from the MSB end.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] code);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            case (code)
                3'b000:  m[b] = 1'b1;
                3'b001:  m[b] = (b < NB / 2);
                3'b010:  m[b] = (b >= NB / 2);
                3'b011:  m[b] = (b % 2 == 0);
                3'b100:  m[b] = (b % 2 == 1);
                default: m[b] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // Effective lane masks already fold in enable, the address-0 hole and the sweep lockout.
    always_comb begin
        mask0 = '0;
        mask1 = '0;
        if (wrEn0 && !clrBusy && wrAddr0 != '0) mask0 = lane_mask(ppp0);
        if (wrEn1 && !clrBusy && wrAddr1 != '0) mask1 = lane_mask(ppp1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pointer   <= FIRST;
            done_flag <= 1'b0;
        end else begin
            state     <= state_next;
            pointer   <= pointer_next;
            done_flag <= (state == SWEEP) && (state_next == IDLE);
        end
    end

    always_comb begin
        state_next   = state;
        pointer_next = pointer;
        case (state)
            IDLE: begin
                if (clrReq) begin
                    state_next   = SWEEP;
                    pointer_next = FIRST;
                end
            end
            SWEEP: begin
                if (pointer == LAST) begin
                    state_next   = IDLE;
                    pointer_next = FIRST;
                end else begin
                    pointer_next = pointer + FIRST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clrBusy = (state == SWEEP);
        clrDone = done_flag;
        wrRdy   = (state != SWEEP);
    end

    // Port 1 lanes are assigned after port 0 so they win on an overlapping lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == SWEEP) begin
            mem[pointer] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (mask0[b]) mem[wrAddr0][DATA_WIDTH-1-8*b -: 8] <= dataIn0[8*b +: 8];
                if (mask1[b]) mem[wrAddr1][DATA_WIDTH-1-8*b -: 8] <= dataIn1[8*b +: 8];
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;
        dataOut = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            rv = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
            for (int b = 0; b < NB; b++) begin
                if (mask0[b] && wrAddr0 == ra) rv[DATA_WIDTH-1-8*b -: 8] = dataIn0[8*b +: 8];
                if (mask1[b] && wrAddr1 == ra) rv[DATA_WIDTH-1-8*b -: 8] = dataIn1[8*b +: 8];
            end
`endif
            if (ra == '0) rv = '0;
            dataOut[k*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end
endmodule

// File: tb/tb_regfile_mp_ppp.sv
// Self-checking bench for regfile_mp_ppp: directed cases, randomized writes against an array model, clear engine.
module tb_regfile_mp_ppp;
    localparam int DEPTH  = 32;
    localparam int DW     = 64;
    localparam int NUM_RD = 3;
    localparam int AW     = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wrEn0, wrEn1;
    logic [AW-1:0]        wrAddr0, wrAddr1;
    logic [0:DW-1]        dataIn0, dataIn1;
    logic [2:0]           ppp0, ppp1;
    logic [NUM_RD*AW-1:0] rdAddr;
    logic [NUM_RD*DW-1:0] dataOut;
    logic                 clrReq, clrBusy, clrDone, wrRdy;

    logic [63:0] model [DEPTH];
    int total = 0;
    int bad   = 0;

    regfile_mp_ppp dut (
        .clk(clk), .reset(reset),
        .wrEn0(wrEn0), .wrEn1(wrEn1), .wrAddr0(wrAddr0), .wrAddr1(wrAddr1),
        .dataIn0(dataIn0), .dataIn1(dataIn1), .ppp0(ppp0), .ppp1(ppp1),
        .rdAddr(rdAddr), .dataOut(dataOut),
        .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone), .wrRdy(wrRdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] lanes(input logic [2:0] p);
        case (p)
            3'b000:  return 64'hFFFFFFFF_FFFFFFFF;
            3'b001:  return 64'hFFFFFFFF_00000000;
            3'b010:  return 64'h00000000_FFFFFFFF;
            3'b011:  return 64'hFF00FF00_FF00FF00;
            3'b100:  return 64'h00FF00FF_00FF00FF;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] rd(input int k);
        return dataOut[k*DW +: DW];
    endfunction

    function automatic logic [63:0] expect_at(input logic [AW-1:0] a);
        return (a == 0) ? 64'h0 : model[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wrEn0 = 0; wrEn1 = 0; wrAddr0 = 0; wrAddr1 = 0;
        dataIn0 = '0; dataIn1 = '0; ppp0 = 0; ppp1 = 0; clrReq = 0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rdAddr = {a2, a1, a0};
    endtask

    task automatic model_write(input logic e, input logic [AW-1:0] a, input logic [63:0] d, input logic [2:0] p);
        if (e && a != 0) model[a] = (model[a] & ~lanes(p)) | (d & lanes(p));
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 64'h0;
    endtask

    task automatic do_write(input logic e0, input logic [AW-1:0] a0, input logic [63:0] d0, input logic [2:0] p0,
                            input logic e1, input logic [AW-1:0] a1, input logic [63:0] d1, input logic [2:0] p1);
        wrEn0 = e0; wrAddr0 = a0; dataIn0 = d0; ppp0 = p0;
        wrEn1 = e1; wrAddr1 = a1; dataIn1 = d1; ppp1 = p1;
        step();
        model_write(e0, a0, d0, p0);
        model_write(e1, a1, d1, p1);
        wrEn0 = 0; wrEn1 = 0;
        #1;
    endtask

    task automatic test_directed();
        do_write(1, 5, 64'h0123456789ABCDEF, 3'b000, 0, 0, 64'h0, 3'b000);
        set_rd(5, 0, 0); #1;
        total++;
        if (rd(0) !== 64'h0123456789ABCDEF) begin
            bad++; $display("[TB] FAIL full_write: got %h expected %h", rd(0), 64'h0123456789ABCDEF);
        end
        do_write(0, 0, 64'h0, 3'b000, 1, 5, 64'hFFFFFFFFFFFFFFFF, 3'b011);
        #1;
        total++;
        if (rd(0) !== 64'hFF23FF67FFABFFEF) begin
            bad++; $display("[TB] FAIL even_bytes: got %h expected %h", rd(0), 64'hFF23FF67FFABFFEF);
        end
        do_write(1, 7, 64'h1111111111111111, 3'b000, 1, 7, 64'h2222222222222222, 3'b010);
        set_rd(7, 5, 7); #1;
        total++;
        if (rd(0) !== 64'h1111111122222222) begin
            bad++; $display("[TB] FAIL merge_port1: got %h expected %h", rd(0), 64'h1111111122222222);
        end
    endtask

    task automatic test_addr0();
        wrEn0 = 1; wrAddr0 = 0; dataIn0 = 64'hDEADBEEFDEADBEEF; ppp0 = 0;
        wrEn1 = 1; wrAddr1 = 0; dataIn1 = 64'hDEADDEADDEADDEAD; ppp1 = 0;
        set_rd(0, 0, 0); #1;
        for (int k = 0; k < NUM_RD; k++) begin
            total++;
            if (rd(k) !== 64'h0) begin
                bad++; $display("[TB] FAIL addr0_same port%0d: got %h expected 0", k, rd(k));
            end
        end
        step();
        wrEn0 = 0; wrEn1 = 0; #1;
        for (int k = 0; k < NUM_RD; k++) begin
            total++;
            if (rd(k) !== 64'h0) begin
                bad++; $display("[TB] FAIL addr0_next port%0d: got %h expected 0", k, rd(k));
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ra [NUM_RD];
        for (int n = 0; n < 60; n++) begin
            do_write(1'($urandom), AW'($urandom_range(0, 7)), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                     1'($urandom), AW'($urandom_range(0, 7)), {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            for (int k = 0; k < NUM_RD; k++) ra[k] = AW'($urandom_range(0, 7));
            set_rd(ra[0], ra[1], ra[2]); #1;
            for (int k = 0; k < NUM_RD; k++) begin
                total++;
                if (rd(k) !== expect_at(ra[k])) begin
                    bad++; $display("[TB] FAIL random n=%0d port%0d addr%0d: got %h expected %h",
                                    n, k, ra[k], rd(k), expect_at(ra[k]));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; clrReq = 1;
        wrEn0 = 1; wrAddr0 = 9; dataIn0 = 64'h123456789ABCDEF0; ppp0 = 0;
        step();
        reset = 0; idle_inputs();
        zero_model();
        #1;
        total++;
        if (clrBusy !== 1'b0 || clrDone !== 1'b0 || wrRdy !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_flags: got busy=%b done=%b rdy=%b expected 0 0 1", clrBusy, clrDone, wrRdy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(AW'(a), 0, 0); #1;
            total++;
            if (rd(0) !== 64'h0) begin
                bad++; $display("[TB] FAIL reset_entry%0d: got %h expected 0", a, rd(0));
            end
        end
        step();
        total++;
        if (clrBusy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_priority: got busy=%b expected 0", clrBusy);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_same;
`ifdef REGFILE_MP_BYPASS_EN
        exp_same = 64'hAAAAAAAA89ABCDEF;
`else
        exp_same = 64'h0123456789ABCDEF;
`endif
        do_write(1, 3, 64'h0123456789ABCDEF, 3'b000, 0, 0, 64'h0, 3'b000);
        wrEn0 = 1; wrAddr0 = 3; dataIn0 = 64'hAAAAAAAAAAAAAAAA; ppp0 = 3'b001;
        set_rd(3, 3, 4); #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rd(k) !== exp_same) begin
                bad++; $display("[TB] FAIL bypass_same port%0d: got %h expected %h", k, rd(k), exp_same);
            end
        end
        step();
        model_write(1, 3, 64'hAAAAAAAAAAAAAAAA, 3'b001);
        wrEn0 = 0; #1;
        total++;
        if (rd(0) !== 64'hAAAAAAAA89ABCDEF) begin
            bad++; $display("[TB] FAIL bypass_next: got %h expected %h", rd(0), 64'hAAAAAAAA89ABCDEF);
        end
        wrEn1 = 1; wrAddr1 = 3; dataIn1 = 64'h5555555555555555; ppp1 = 3'b101; #1;
        total++;
        if (rd(0) !== 64'hAAAAAAAA89ABCDEF) begin
            bad++; $display("[TB] FAIL dropped_same: got %h expected %h", rd(0), 64'hAAAAAAAA89ABCDEF);
        end
        step();
        wrEn1 = 0; #1;
        total++;
        if (rd(0) !== 64'hAAAAAAAA89ABCDEF) begin
            bad++; $display("[TB] FAIL dropped_next: got %h expected %h", rd(0), 64'hAAAAAAAA89ABCDEF);
        end
    endtask

    task automatic test_clear();
        int busy;
        for (int a = 1; a < DEPTH; a++)
            do_write(1, AW'(a), {$urandom, $urandom}, 3'b000, 0, 0, 64'h0, 3'b000);
        clrReq = 1;
        step();
        clrReq = 0;
        busy = 0;
        while (clrBusy === 1'b1 && busy < 40) begin
            busy++;
            clrReq = (busy == 5);
            wrEn0 = 1; wrAddr0 = AW'($urandom_range(1, DEPTH-1)); dataIn0 = {$urandom, $urandom}; ppp0 = 0;
            wrEn1 = 1; wrAddr1 = AW'($urandom_range(1, DEPTH-1)); dataIn1 = {$urandom, $urandom}; ppp1 = 0;
            set_rd(AW'(busy), AW'(busy - 1), 0); #1;
            total++;
            if (clrDone !== 1'b0 || wrRdy !== 1'b0) begin
                bad++; $display("[TB] FAIL sweep_flags cyc%0d: got done=%b rdy=%b expected 0 0", busy, clrDone, wrRdy);
            end
            if (busy < DEPTH) begin
                total++;
                if (rd(0) !== model[busy] || rd(1) !== 64'h0) begin
                    bad++; $display("[TB] FAIL sweep_read cyc%0d: got %h/%h expected %h/0",
                                    busy, rd(0), rd(1), model[busy]);
                end
                model[busy] = 64'h0;
            end
            step();
        end
        idle_inputs(); #1;
        total++;
        if (busy != DEPTH - 1) begin
            bad++; $display("[TB] FAIL busy_cycles: got %0d expected %0d", busy, DEPTH - 1);
        end
        total++;
        if (clrDone !== 1'b1 || wrRdy !== 1'b1) begin
            bad++; $display("[TB] FAIL done_pulse: got done=%b rdy=%b expected 1 1", clrDone, wrRdy);
        end
        step();
        total++;
        if (clrDone !== 1'b0 || clrBusy !== 1'b0) begin
            bad++; $display("[TB] FAIL done_after: got done=%b busy=%b expected 0 0", clrDone, clrBusy);
        end
        zero_model();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(AW'(a), 0, 0); #1;
            total++;
            if (rd(0) !== 64'h0) begin
                bad++; $display("[TB] FAIL cleared_entry%0d: got %h expected 0", a, rd(0));
            end
        end
    endtask

    task automatic test_clear_abort();
        do_write(1, 20, 64'hCAFEF00DCAFEF00D, 3'b000, 0, 0, 64'h0, 3'b000);
        clrReq = 1;
        step();
        clrReq = 0;
        for (int i = 0; i < 9; i++) step();
        total++;
        if (clrBusy !== 1'b1) begin
            bad++; $display("[TB] FAIL abort_busy: got %b expected 1", clrBusy);
        end
        reset = 1;
        step();
        reset = 0;
        zero_model();
        #1;
        total++;
        if (clrBusy !== 1'b0 || clrDone !== 1'b0 || wrRdy !== 1'b1) begin
            bad++; $display("[TB] FAIL abort_flags: got busy=%b done=%b rdy=%b expected 0 0 1", clrBusy, clrDone, wrRdy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (clrDone !== 1'b0 || clrBusy !== 1'b0) begin
                bad++; $display("[TB] FAIL abort_nodone%0d: got done=%b busy=%b expected 0 0", i, clrDone, clrBusy);
            end
        end
        set_rd(20, 0, 0); #1;
        total++;
        if (rd(0) !== 64'h0) begin
            bad++; $display("[TB] FAIL abort_entry: got %h expected 0", rd(0));
        end
    endtask

    initial begin
        idle_inputs();
        rdAddr = '0;
        zero_model();
        reset = 1;
        step();
        step();
        reset = 0;
        test_directed();
        test_addr0();
        test_random();
        test_reset();
        test_bypass();
        test_clear();
        test_clear_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
